// File: rtl/regfile_bypass_sb.sv
// Two-write, two-read integer register file with optional write-to-read bypass
// and a pending-load scoreboard with a registered busy-register count.
module regfile_bypass_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int A      = $clog2(NREGS),
  parameter int BYPASS = 1,
  parameter int CW     = $clog2(NREGS) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [A-1:0]    rs1_addr,
  input  logic [A-1:0]    rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we_a,
  input  logic [A-1:0]    waddr_a,
  input  logic [XLEN-1:0] wdata_a,
  input  logic            we_b,
  input  logic [A-1:0]    waddr_b,
  input  logic [XLEN-1:0] wdata_b,
  input  logic            sb_set,
  input  logic [A-1:0]    sb_addr,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    pending_cnt_q, pending_cnt_d;

  // Effective operations: anything aimed at x0 is dropped here once.
  logic wr_a, wr_b, set_v;
  assign wr_a  = we_a   && (waddr_a != '0);
  assign wr_b  = we_b   && (waddr_b != '0);
  assign set_v = sb_set && (sb_addr != '0);

  // NOTE: every combinational output is given a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (wr_a) regs_d[waddr_a] = wdata_a;
    if (wr_b) regs_d[waddr_b] = wdata_b;
    regs_d[0] = '0;
  end

  // A load issued in the same cycle as an older load's return keeps the register busy.
  logic cnt_inc, cnt_dec;
  always_comb begin
    busy_d = busy_q;
    if (wr_b)  busy_d[waddr_b] = 1'b0;
    if (set_v) busy_d[sb_addr] = 1'b1;
    busy_d[0] = 1'b0;

    cnt_inc = set_v && !busy_q[sb_addr];
    cnt_dec = wr_b && busy_q[waddr_b] && !(set_v && (sb_addr == waddr_b));
    pending_cnt_d = pending_cnt_q + {{(CW-1){1'b0}}, cnt_inc}
                                  - {{(CW-1){1'b0}}, cnt_dec};
  end

  // NOTE: the storage array is reset along with the control state because
  // architectural registers must read zero after reset; this rules out RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // pre-edge values regardless of statement order.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  logic [A-1:0]    rd_addr [2];
  logic [XLEN-1:0] rd_data [2];
  logic            rd_busy [2];

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  // Port B is applied after port A so it wins on an address collision.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS != 0) begin
        if (wr_a && (waddr_a == rd_addr[p])) rd_data[p] = wdata_a;
        if (wr_b && (waddr_b == rd_addr[p])) begin
          rd_data[p] = wdata_b;
          rd_busy[p] = 1'b0;
        end
      end
      if (rst || (rd_addr[p] == '0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign rs1_data    = rd_data[0];
  assign rs2_data    = rd_data[1];
  assign rs1_busy    = rd_busy[0];
  assign rs2_busy    = rd_busy[1];
  assign pending_cnt = pending_cnt_q;

  // The incremental count must always agree with the busy vector it tracks.
  a_cnt_matches_busy: assert property (@(posedge clk) disable iff (rst)
    pending_cnt_q == CW'($countones(busy_q)));
  a_x0_never_busy: assert property (@(posedge clk) disable iff (rst)
    busy_q[0] == 1'b0);

endmodule
